// File: rtl/lb_pkg.sv
// Shared defaults, pixel type and window indexing helper for the line buffer
// window generator and its consumers (cnn_kernel benches).
package lb_pkg;

    localparam int LB_IMG_W  = 28;
    localparam int LB_IMG_H  = 28;
    localparam int LB_KX     = 5;
    localparam int LB_KY     = 5;
    localparam int LB_I_F_BW = 8;

    typedef logic [LB_I_F_BW-1:0] pixel_t;

    // Flattened element index of window position (ky, kx); 0 is top-left/oldest.
    function automatic int win_idx(input int ky, input int kx);
        return ky * LB_KX + kx;
    endfunction

endpackage

// File: rtl/line_buffer_window_gen_row_ram.sv
// One line-buffer row: IMG_W deep, synchronous write, asynchronous read.
// Contents are deliberately not reset; consumers qualify reads by position.
module lb_row_ram #(
    parameter int DEPTH = 28,
    parameter int W     = 8,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] addr,
    input  logic [W-1:0]  wr_data,
    output logic [W-1:0]  rd_data
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[addr] <= wr_data;
        end
    end

    assign rd_data = mem[addr];

endmodule

// File: rtl/line_buffer_window_gen.sv
// Raster pixel stream to KX x KY sliding-window generator (stride 1, valid conv).
// Define LB_STRIDE2_EN to emit only every second window in both directions.
module line_buffer_window_gen
    import lb_pkg::*;
#(
    parameter int IMG_W  = LB_IMG_W,
    parameter int IMG_H  = LB_IMG_H,
    parameter int KX     = LB_KX,
    parameter int KY     = LB_KY,
    parameter int I_F_BW = LB_I_F_BW
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     i_in_valid,
    input  logic [I_F_BW-1:0]        i_in_pixel,
    output logic                     o_ot_valid,
    output logic [KX*KY*I_F_BW-1:0]  o_ot_window,
    output logic                     o_ot_frame_done
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int WB = KX * KY * I_F_BW;

    localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_START = CW'(KX - 1);
    localparam logic [RW-1:0] ROW_START = RW'(KY - 1);

    if (IMG_W < KX || IMG_H < KY) begin : g_param_check
        $error("line_buffer_window_gen: image must be at least as large as the window");
    end

    logic [CW-1:0]     col;
    logic [RW-1:0]     row;
    logic              col_last;
    logic              row_last;
    logic              q;
    logic              done_next;
    logic [I_F_BW-1:0] lb_rd   [KY-1];
    logic [I_F_BW-1:0] col_vec [KY];
    logic [WB-1:0]     win;
    logic [WB-1:0]     win_next;

    assign col_last = (col == COL_LAST);
    assign row_last = (row == ROW_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            col <= '0;
            row <= '0;
        end else if (i_in_valid) begin
            if (col_last) begin
                col <= '0;
                row <= row_last ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // Left-edge columns hold previous-row data in the window, so the col gate
    // is what keeps windows from straddling rows.
`ifdef LB_STRIDE2_EN
    assign q = i_in_valid && (row >= ROW_START) && (col >= COL_START)
               && (row[0] == ROW_START[0]) && (col[0] == COL_START[0]);
    assign done_next = i_in_valid && row_last && col_last;
`else
    assign q = i_in_valid && (row >= ROW_START) && (col >= COL_START);
    assign done_next = q && row_last && col_last;
`endif

    for (genvar k = 0; k < KY - 1; k++) begin : g_lb
        logic [I_F_BW-1:0] wr_data;
        if (k == 0) begin : g_head
            assign wr_data = i_in_pixel;
        end else begin : g_chain
            assign wr_data = lb_rd[k-1];
        end
        lb_row_ram #(
            .DEPTH (IMG_W),
            .W     (I_F_BW),
            .AW    (CW)
        ) u_row (
            .clk     (clk),
            .wr_en   (i_in_valid),
            .addr    (col),
            .wr_data (wr_data),
            .rd_data (lb_rd[k])
        );
    end

    for (genvar ky = 0; ky < KY - 1; ky++) begin : g_col
        assign col_vec[ky] = lb_rd[KY-2-ky];
    end
    assign col_vec[KY-1] = i_in_pixel;

    for (genvar ky = 0; ky < KY; ky++) begin : g_win_y
        for (genvar kx = 0; kx < KX; kx++) begin : g_win_x
            if (kx < KX - 1) begin : g_shift
                assign win_next[(ky*KX+kx)*I_F_BW +: I_F_BW] = win[(ky*KX+kx+1)*I_F_BW +: I_F_BW];
            end else begin : g_enter
                assign win_next[(ky*KX+kx)*I_F_BW +: I_F_BW] = col_vec[ky];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            win             <= '0;
            o_ot_valid      <= 1'b0;
            o_ot_frame_done <= 1'b0;
        end else begin
            o_ot_valid      <= q;
            o_ot_frame_done <= done_next;
            if (i_in_valid) begin
                win <= win_next;
            end
        end
    end

    assign o_ot_window = win;

endmodule

// File: tb/tb_line_buffer_window_gen.sv
// Directed bench for line_buffer_window_gen: image-array reference model plus
// hand-computed spot values for the first, row-advance and last windows.
module tb_line_buffer_window_gen;
    import lb_pkg::*;

    localparam int W  = LB_IMG_W;
    localparam int H  = LB_IMG_H;
    localparam int KX = LB_KX;
    localparam int KY = LB_KY;
    localparam int BW = LB_I_F_BW;
    localparam int WB = KX * KY * BW;
`ifdef LB_STRIDE2_EN
    localparam int EXP_WIN = ((H - KY + 2) / 2) * ((W - KX + 2) / 2);
`else
    localparam int EXP_WIN = (H - KY + 1) * (W - KX + 1);
`endif

    logic          clk = 1'b0;
    logic          reset_n;
    logic          i_in_valid;
    logic [BW-1:0] i_in_pixel;
    logic          o_ot_valid;
    logic [WB-1:0] o_ot_window;
    logic          o_ot_frame_done;

    always #5 clk = ~clk;

    line_buffer_window_gen dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .i_in_valid      (i_in_valid),
        .i_in_pixel      (i_in_pixel),
        .o_ot_valid      (o_ot_valid),
        .o_ot_window     (o_ot_window),
        .o_ot_frame_done (o_ot_frame_done)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [WB-1:0] got, input logic [WB-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [WB-1:0] add1(input logic [WB-1:0] w);
        logic [WB-1:0] r;
        for (int e = 0; e < KX * KY; e++) r[e*BW +: BW] = w[e*BW +: BW] + BW'(1);
        return r;
    endfunction

    // Reference model: stores every accepted pixel in an image array and reads
    // the expected window straight out of it.
    logic [BW-1:0] img [H][W];
    int            mr, mc;
    logic          exp_valid, exp_done, acc_d;
    logic [WB-1:0] exp_win;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mr = 0; mc = 0; exp_valid = 1'b0; exp_done = 1'b0; acc_d = 1'b0; exp_win = '0;
        end else begin
            bit q, last;
            acc_d     = i_in_valid;
            exp_valid = 1'b0;
            exp_done  = 1'b0;
            if (i_in_valid) begin
                img[mr][mc] = i_in_pixel;
                q = (mr >= KY - 1) && (mc >= KX - 1);
`ifdef LB_STRIDE2_EN
                q = q && ((mr - (KY - 1)) % 2 == 0) && ((mc - (KX - 1)) % 2 == 0);
`endif
                last = (mr == H - 1) && (mc == W - 1);
                if (q) begin
                    exp_valid = 1'b1;
                    for (int ky = 0; ky < KY; ky++)
                        for (int kx = 0; kx < KX; kx++)
                            exp_win[win_idx(ky, kx)*BW +: BW] = img[mr-(KY-1)+ky][mc-(KX-1)+kx];
                end
`ifdef LB_STRIDE2_EN
                exp_done = last;
`else
                exp_done = q && last;
`endif
                if (mc == W - 1) begin
                    mc = 0;
                    mr = (mr == H - 1) ? 0 : mr + 1;
                end else begin
                    mc = mc + 1;
                end
            end
        end
    end

    bit            mon_en = 1'b0;
    int            pulses, dones;
    logic [WB-1:0] prev_win, done_win;
    logic [WB-1:0] got_q [$];
    logic [WB-1:0] ref_q [$];

    always @(negedge clk) begin
        if (!reset_n) begin
            prev_win = '0;
        end else if (mon_en) begin
            chk("valid", o_ot_valid, exp_valid);
            chk("frame_done", o_ot_frame_done, exp_done);
            if (exp_valid) chk("window", o_ot_window, exp_win);
            else if (!acc_d) chk("hold", o_ot_window, prev_win);
            if (o_ot_valid) begin
                pulses++;
                got_q.push_back(o_ot_window);
            end
            if (o_ot_frame_done) begin
                dones++;
                done_win = o_ot_window;
            end
            prev_win = o_ot_window;
        end
    end

    task automatic clear_stats();
        pulses = 0;
        dones  = 0;
        got_q.delete();
    endtask

    task automatic send_frame(input int off, input bit gaps, input int npix);
        for (int p = 0; p < npix; p++) begin
            if (gaps) begin
                int g = $urandom_range(0, 2);
                repeat (g) begin
                    @(posedge clk); #1;
                    i_in_valid = 1'b0;
                    i_in_pixel = BW'($urandom);
                end
            end
            @(posedge clk); #1;
            i_in_valid = 1'b1;
            i_in_pixel = BW'(p + off);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            i_in_valid = 1'b0;
        end
    endtask

    task automatic cmp_ref(input string tag, input bit plus1);
        chk({tag, "_count"}, got_q.size(), ref_q.size());
        for (int i = 0; i < ref_q.size() && i < got_q.size(); i++)
            chk(tag, got_q[i], plus1 ? add1(ref_q[i]) : ref_q[i]);
    endtask

    initial begin
        logic [WB-1:0] w;
        reset_n    = 1'b0;
        i_in_valid = 1'b0;
        i_in_pixel = '0;
        clear_stats();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", o_ot_valid, 0);
        chk("rst_window", o_ot_window, 0);
        chk("rst_frame_done", o_ot_frame_done, 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        mon_en  = 1'b1;

        // continuous ramp frame
        send_frame(0, 1'b0, W * H);
        idle(3);
        chk("ramp_pulses", pulses, EXP_WIN);
        chk("ramp_dones", dones, 1);
        w = got_q.size() > 0 ? got_q[0] : '0;
        chk("first_e0", w[0*BW +: BW], 0);
        chk("first_e4", w[4*BW +: BW], 4);
        chk("first_e20", w[20*BW +: BW], 112);
        chk("first_e24", w[24*BW +: BW], 116);
`ifdef LB_STRIDE2_EN
        w = got_q.size() > 1 ? got_q[1] : '0;
        chk("second_e0", w[0*BW +: BW], 2);
        w = got_q.size() > 12 ? got_q[12] : '0;
        chk("row_adv_e0", w[0*BW +: BW], 56);
`else
        w = got_q.size() > 24 ? got_q[24] : '0;
        chk("row5_e0", w[0*BW +: BW], 28);
        chk("done_e24", done_win[(KX*KY-1)*BW +: BW], BW'(H * W - 1));
`endif
        ref_q = got_q;

        // same frame with random valid gaps
        clear_stats();
        send_frame(0, 1'b1, W * H);
        idle(3);
        cmp_ref("gaps", 1'b0);
        chk("gaps_dones", dones, 1);

        // reset in mid-frame, then a full frame
        clear_stats();
        send_frame(0, 1'b0, 100);
        @(posedge clk); #1;
        i_in_valid = 1'b0;
        reset_n    = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        send_frame(0, 1'b0, W * H);
        idle(3);
        cmp_ref("after_rst", 1'b0);
        chk("after_rst_dones", dones, 1);

        // two back-to-back frames, second offset by one
        clear_stats();
        send_frame(0, 1'b0, W * H);
        send_frame(1, 1'b0, W * H);
        idle(3);
        chk("b2b_pulses", pulses, 2 * EXP_WIN);
        chk("b2b_dones", dones, 2);
        for (int i = 0; i < EXP_WIN && EXP_WIN + i < got_q.size(); i++) begin
            chk("b2b_f1", got_q[i], ref_q[i]);
            chk("b2b_f2", got_q[EXP_WIN+i], add1(ref_q[i]));
        end

        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
